// File: rtl/btn_conditioner.sv
// btn_conditioner: per-channel synchroniser, debouncer and press/release/auto-repeat pulse generator
module btn_conditioner #(
    parameter int N_BTN            = 3,
    parameter int ACTIVE_LOW       = 0,
    parameter int DEBOUNCE_CYC     = 270000,
    parameter int REPEAT_DELAY_CYC = 13500000,
    parameter int REPEAT_RATE_CYC  = 2700000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_held
);
    localparam int DW   = $clog2(DEBOUNCE_CYC) + 1;
    localparam int HMAX = REPEAT_DELAY_CYC > REPEAT_RATE_CYC ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int HW   = $clog2(HMAX) + 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] DL_LAST = HW'(REPEAT_DELAY_CYC - 1);
    localparam logic [HW-1:0] RT_LAST = HW'(REPEAT_RATE_CYC - 1);
    localparam logic          POL     = ACTIVE_LOW != 0;
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRESSED = 2'd1;
    localparam logic [1:0] REPEAT  = 2'd2;

    genvar g;
    generate
        for (g = 0; g < N_BTN; g++) begin : g_ch
            logic          s1, s2, lvl, prs, rel, hld, diff, acc;
            logic [DW-1:0] dcnt;
            logic [HW-1:0] hcnt;
            logic [1:0]    st;
            assign diff = s2 != lvl;
            // acc marks the edge where o_level flips, so the FSM can pulse in that same cycle
            assign acc  = diff && dcnt == DB_LAST;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    s1   <= 1'b0;
                    s2   <= 1'b0;
                    lvl  <= 1'b0;
                    prs  <= 1'b0;
                    rel  <= 1'b0;
                    hld  <= 1'b0;
                    dcnt <= '0;
                    hcnt <= '0;
                    st   <= IDLE;
                end else begin
                    s1   <= i_btn[g] ^ POL;
                    s2   <= s1;
                    dcnt <= (!diff || acc) ? '0 : (dcnt != '1 ? dcnt + 1'b1 : dcnt);
                    if (acc)
                        lvl <= s2;
                    prs <= 1'b0;
                    rel <= 1'b0;
                    case (st)
                        IDLE: if (acc && s2) begin
                            prs  <= 1'b1;
                            hcnt <= '0;
                            st   <= PRESSED;
                        end
                        PRESSED: if (acc) begin
                            rel <= 1'b1;
                            st  <= IDLE;
                        end else if (REPEAT_DELAY_CYC != 0 && hcnt == DL_LAST) begin
                            prs  <= 1'b1;
                            hld  <= 1'b1;
                            hcnt <= '0;
                            st   <= REPEAT;
                        end else begin
                            hcnt <= hcnt != '1 ? hcnt + 1'b1 : hcnt;
                        end
                        REPEAT: if (acc) begin
                            rel <= 1'b1;
                            hld <= 1'b0;
                            st  <= IDLE;
                        end else if (hcnt == RT_LAST) begin
                            prs  <= 1'b1;
                            hcnt <= '0;
                        end else begin
                            hcnt <= hcnt != '1 ? hcnt + 1'b1 : hcnt;
                        end
                        default: st <= IDLE;
                    endcase
                end
            end
            assign o_level[g]   = lvl;
            assign o_press[g]   = prs;
            assign o_release[g] = rel;
            assign o_held[g]    = hld;
        end
    endgenerate
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: three DUT flavours (repeat on, repeat off, active-low) checked against a window/arithmetic model
module tb_btn_conditioner;
    localparam int DB   = 4;
    localparam int DLY  = 20;
    localparam int RATE = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] btn = 3'b000;
    logic [2:0] lv0, pr0, rl0, hd0, lv1, pr1, rl1, hd1, lv2, pr2, rl2, hd2;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    btn_conditioner #(.N_BTN(3), .ACTIVE_LOW(0), .DEBOUNCE_CYC(DB), .REPEAT_DELAY_CYC(DLY), .REPEAT_RATE_CYC(RATE)) u0 (
        .i_clk(clk), .i_rst(rst), .i_btn(btn), .o_level(lv0), .o_press(pr0), .o_release(rl0), .o_held(hd0));
    btn_conditioner #(.N_BTN(3), .ACTIVE_LOW(0), .DEBOUNCE_CYC(DB), .REPEAT_DELAY_CYC(0), .REPEAT_RATE_CYC(RATE)) u1 (
        .i_clk(clk), .i_rst(rst), .i_btn(btn), .o_level(lv1), .o_press(pr1), .o_release(rl1), .o_held(hd1));
    btn_conditioner #(.N_BTN(3), .ACTIVE_LOW(1), .DEBOUNCE_CYC(DB), .REPEAT_DELAY_CYC(DLY), .REPEAT_RATE_CYC(RATE)) u2 (
        .i_clk(clk), .i_rst(rst), .i_btn(~btn), .o_level(lv2), .o_press(pr2), .o_release(rl2), .o_held(hd2));

    task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    endtask

    // Model: hist[c][j] is the pressed sample taken j+1 edges ago; the level flips once the
    // DB samples that have crossed the synchroniser all disagree with it.
    bit [31:0] hist [3];
    bit [2:0]  m_lvl, m_rel;
    bit [2:0]  m_press [2];
    bit [2:0]  m_held [2];
    int        m_ht [2][3];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist = '{default: 0};
            m_lvl = '0;
            m_rel = '0;
            m_press = '{default: 0};
            m_held = '{default: 0};
            m_ht = '{default: 0};
        end else begin
            for (int c = 0; c < 3; c++) begin
                bit flip, rise;
                int d;
                flip = 1'b1;
                for (int j = 1; j <= DB; j++)
                    if (hist[c][j] == m_lvl[c]) flip = 1'b0;
                hist[c] = {hist[c][30:0], btn[c]};
                rise = flip && !m_lvl[c];
                m_rel[c] = flip && m_lvl[c];
                if (flip) m_lvl[c] = !m_lvl[c];
                for (int m = 0; m < 2; m++) begin
                    d = m == 0 ? DLY : 0;
                    if (rise) begin
                        m_ht[m][c] = 0;
                        m_press[m][c] = 1'b1;
                    end else if (m_lvl[c]) begin
                        m_ht[m][c]++;
                        m_press[m][c] = d != 0 && m_ht[m][c] >= d && (m_ht[m][c] - d) % RATE == 0;
                    end else begin
                        m_press[m][c] = 1'b0;
                    end
                    m_held[m][c] = m_lvl[c] && d != 0 && m_ht[m][c] >= d;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("u0_level", lv0, m_lvl);
            chk("u0_press", pr0, m_press[0]);
            chk("u0_release", rl0, m_rel);
            chk("u0_held", hd0, m_held[0]);
            chk("u1_level", lv1, m_lvl);
            chk("u1_press", pr1, m_press[1]);
            chk("u1_release", rl1, m_rel);
            chk("u1_held", hd1, m_held[1]);
            chk("u2_level", lv2, m_lvl);
            chk("u2_press", pr2, m_press[0]);
            chk("u2_release", rl2, m_rel);
            chk("u2_held", hd2, m_held[0]);
            chk("u0_excl", pr0 & rl0, 3'b000);
        end
    end

    initial begin
        bit [7:0] pat;
        logic [2:0] exp;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_u0", lv0 | pr0 | rl0 | hd0, 3'b000);
        chk("rst_u2", lv2 | pr2 | rl2 | hd2, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        btn = 3'b001;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            #1;
            exp = {2'b00, e == 6 || e == 26 || e == 34 || e == 42 || e == 50 || e == 58};
            chk("rep_press", pr0, exp);
            chk("rep_model", m_press[0], exp);
            chk("rep_held", hd0, {2'b00, e >= 26});
            chk("rep_level", lv0, {2'b00, e >= 6});
            chk("norep_press", pr1, {2'b00, e == 6});
            chk("norep_held", hd1, 3'b000);
        end
        @(negedge clk);
        btn = 3'b000;
        for (int r = 1; r <= 8; r++) begin
            @(posedge clk);
            #1;
            chk("rel_pulse", rl0, {2'b00, r == 6});
            chk("rel_held", hd0, {2'b00, r < 6});
            chk("rel_press", pr0, 3'b000);
        end
        pat = 8'b11100111;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            btn[1] = i < 8 ? pat[7 - i] : 1'b0;
            @(posedge clk);
            #1;
            chk("bounce", {lv0[1], pr0[1], rl0[1]}, 3'b000);
        end
        repeat (10) @(negedge clk);
        btn = 3'b001;
        repeat (40) @(posedge clk);
        #1;
        chk("pre_rst_held", hd0, 3'b001);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_u0", lv0 | pr0 | rl0 | hd0, 3'b000);
        chk("arst_u1", lv1 | pr1 | rl1 | hd1, 3'b000);
        chk("arst_u2", lv2 | pr2 | rl2 | hd2, 3'b000);
        @(posedge clk);
        #1;
        chk("arst_norel", rl0, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            chk("post_rst_press", pr0, {2'b00, e == 6});
            chk("post_rst_rel", rl0, 3'b000);
        end
        @(negedge clk);
        btn = 3'b000;
        repeat (20) @(negedge clk);
        btn = 3'b101;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            chk("sim_press", pr2, e == 6 ? 3'b101 : 3'b000);
            chk("sim_level", lv2, e >= 6 ? 3'b101 : 3'b000);
            chk("sim_model", m_press[0], e == 6 ? 3'b101 : 3'b000);
        end
        for (int ph = 0; ph < 4; ph++) begin
            for (int k = 0; k < 1500; k++) begin
                @(negedge clk);
                for (int c = 0; c < 3; c++)
                    if ($urandom_range(0, ph == 0 ? 2 : ph == 1 ? 9 : ph == 2 ? 39 : 5) == 0)
                        btn[c] = ~btn[c];
            end
        end
        @(negedge clk);
        btn = 3'b000;
        repeat (15) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
